// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: PC handshake, imem request/response and decode-facing valid/ready channel.
// master is the fetch stage itself; slave is the surrounding PC/imem/decode environment.
interface fetch_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] pc_in;
   logic              pc_advance;
   logic [ADDR_W-1:0] pc_next;
   logic              flush;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic              if_valid;
   logic              if_ready;
   logic [ADDR_W-1:0] if_pc;
   logic [ADDR_W-1:0] if_pc_plus4;
   logic [DATA_W-1:0] if_instr;
   logic              fetch_fault;

   modport master (
      input  pc_in, flush, req_ready, resp_valid, resp_data, if_ready,
      output pc_advance, pc_next, req_valid, req_addr,
             if_valid, if_pc, if_pc_plus4, if_instr, fetch_fault
   );

   modport slave (
      output pc_in, flush, req_ready, resp_valid, resp_data, if_ready,
      input  pc_advance, pc_next, req_valid, req_addr,
             if_valid, if_pc, if_pc_plus4, if_instr, fetch_fault
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: issues in-order imem reads from pc_in into a DEPTH-entry tagged buffer; accept->if_valid is 2 cycles.
// Issue stalls when the buffer is full, on flush or fault; decode backpressure holds entries; flush drops in-flight data.
module fetch_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master fif
);
   localparam int PTR_W = $clog2(DEPTH);
   // Headroom for several back-to-back flushes while a slow memory still owes responses.
   localparam int DROP_W = PTR_W + 4;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT1    = (PTR_W+1)'(1);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   logic [1:0]        st_q    [DEPTH];
   logic [ADDR_W-1:0] pc_q    [DEPTH];
   logic [DATA_W-1:0] instr_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [DROP_W-1:0] drop_cnt;
   logic              fault_q;

   logic [PTR_W:0]    n_occ;
   logic [PTR_W:0]    n_wait;
   logic              wait_found;
   logic [PTR_W-1:0]  wait_idx;
   logic [PTR_W-1:0]  scan_idx;
   logic [DROP_W-1:0] drop_sum;
   logic [DROP_W-1:0] drop_next;
   logic              aligned;
   logic              accept;
   logic              fill;
   logic              pop;

   // Entries sit in ring order from rd_ptr: READY ones first, then WAIT ones.
   always_comb begin
      n_occ      = '0;
      n_wait     = '0;
      wait_found = 1'b0;
      wait_idx   = rd_ptr;
      scan_idx   = rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         if (st_q[i] != ST_EMPTY) n_occ = n_occ + CNT1;
         if (st_q[i] == ST_WAIT)  n_wait = n_wait + CNT1;
      end
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_ptr + PTR_W'(i);
         if (!wait_found && st_q[scan_idx] == ST_WAIT) begin
            wait_found = 1'b1;
            wait_idx   = scan_idx;
         end
      end
      drop_sum  = drop_cnt + DROP_W'(n_wait);
      drop_next = (fif.resp_valid && drop_sum != '0) ? drop_sum - DROP_W'(1) : drop_sum;
   end

   assign aligned         = (fif.pc_in[1:0] == 2'b00);
   assign fif.req_valid   = !reset && !fif.flush && !fault_q && aligned && (n_occ < DEPTH_C);
   assign accept          = fif.req_valid && fif.req_ready;
   assign fif.pc_advance  = accept;
   assign fif.pc_next     = fif.pc_in + ADDR_W'(4);
   assign fif.req_addr    = fif.pc_in;
   assign fill            = fif.resp_valid && (drop_cnt == '0) && wait_found;
   assign fif.if_valid    = (st_q[rd_ptr] == ST_READY) && !fif.flush;
   assign pop             = fif.if_valid && fif.if_ready;
   assign fif.if_pc       = pc_q[rd_ptr];
   assign fif.if_pc_plus4 = pc_q[rd_ptr] + ADDR_W'(4);
   assign fif.if_instr    = instr_q[rd_ptr];
   assign fif.fetch_fault = fault_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i]    <= ST_EMPTY;
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         drop_cnt <= '0;
         fault_q  <= 1'b0;
      end else begin
         if (!aligned) fault_q <= 1'b1;
         if (fif.flush) begin
            for (int i = 0; i < DEPTH; i++) st_q[i] <= ST_EMPTY;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            drop_cnt <= drop_next;
         end else begin
            // accept hits an EMPTY slot, fill a WAIT slot, pop a READY slot: never the same index.
            if (accept) begin
               st_q[wr_ptr] <= ST_WAIT;
               pc_q[wr_ptr] <= fif.pc_in;
               wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (fill) begin
               st_q[wait_idx]    <= ST_READY;
               instr_q[wait_idx] <= fif.resp_data;
            end
            if (pop) begin
               st_q[rd_ptr] <= ST_EMPTY;
               rd_ptr       <= rd_ptr + PTR_W'(1);
            end
            if (fif.resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - DROP_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC and imem models drive the stage, a queue of accepted PCs scores decode output.
// Runs with DEPTH=4 so a 1-cycle imem can sustain one instruction per cycle.
module tb_fetch_stage;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) fif ();
   fetch_stage #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .fif   (fif)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        exp_q[$];
   logic [31:0] pend_q[$];
   bit          auto_mem;
   logic        obs_acc, obs_pop, obs_flush;
   logic [31:0] obs_pc, obs_instr, acc_addr;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // One clock: sample outputs at negedge, then act as PC register and imem after the edge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      obs_acc   = fif.req_valid & fif.req_ready;
      obs_pop   = fif.if_valid & fif.if_ready;
      obs_flush = fif.flush;
      obs_pc    = fif.if_pc;
      obs_instr = fif.if_instr;
      acc_addr  = fif.req_addr;
      @(posedge clk);
      #1;
      fif.resp_valid = 1'b0;
      if (obs_flush) exp_q.delete();
      if (obs_acc) begin
         pend_q.push_back(acc_addr);
         e.pc    = acc_addr;
         e.instr = imem(acc_addr);
         exp_q.push_back(e);
         fif.pc_in = acc_addr + 32'd4;
      end
      if (auto_mem && pend_q.size() > 0) begin
         fif.resp_valid = 1'b1;
         fif.resp_data  = imem(pend_q.pop_front());
      end
   endtask

   task automatic restart();
      reset          = 1'b1;
      fif.flush      = 1'b0;
      fif.req_ready  = 1'b0;
      fif.resp_valid = 1'b0;
      fif.resp_data  = '0;
      fif.if_ready   = 1'b0;
      auto_mem       = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      pend_q.delete();
   endtask

   task automatic test_reset();
      exp_t e;
      int   npop;
      restart();
      reset = 1'b1;
      #2;
      n_tests++; if (fif.req_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", fif.req_valid); end
      n_tests++; if (fif.pc_advance !== 1'b0)  begin n_fail++; $display("FAIL rst_pc_advance: got %b want 0", fif.pc_advance); end
      n_tests++; if (fif.if_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_if_valid: got %b want 0", fif.if_valid); end
      n_tests++; if (fif.if_pc !== 32'h0)      begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", fif.if_pc); end
      n_tests++; if (fif.if_instr !== 32'h0)   begin n_fail++; $display("FAIL rst_if_instr: got %h want 0", fif.if_instr); end
      n_tests++; if (fif.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fif.fetch_fault); end
      @(posedge clk);
      #1;
      reset         = 1'b0;
      fif.req_ready = 1'b1;
      cycle();
      cycle();
      fif.req_ready = 1'b0;
      n_tests++; if (pend_q.size() != 2) begin n_fail++; $display("FAIL rst_two_wait: got %0d accepts want 2", pend_q.size()); end
      // Async reset lands mid-cycle with both fetches still in flight.
      #2 reset = 1'b1;
      #1;
      n_tests++; if (fif.if_valid !== 1'b0 || fif.req_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got if_valid=%b req_valid=%b want 0/0", fif.if_valid, fif.req_valid);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      fif.if_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (pend_q.size() > 0) begin
            fif.resp_valid = 1'b1;
            fif.resp_data  = imem(pend_q.pop_front());
         end
         cycle();
         n_tests++; if (obs_pop !== 1'b0) begin n_fail++; $display("FAIL rst_stale_fill: got pop pc %h want no output", obs_pc); end
      end
      fif.pc_in     = 32'h80;
      fif.req_ready = 1'b1;
      auto_mem      = 1'b1;
      npop          = 0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (obs_pop) begin
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rst_pop: got pc %h want nothing", obs_pc); end
            else begin
               e = exp_q.pop_front();
               if (obs_pc !== e.pc || obs_instr !== e.instr || (npop == 0 && obs_pc !== 32'h80)) begin
                  n_fail++; $display("FAIL rst_pop: got %h/%h want %h/%h", obs_pc, obs_instr, e.pc, e.instr);
               end
            end
            npop++;
         end
      end
      n_tests++; if (npop < 3) begin n_fail++; $display("FAIL rst_resume: got %0d pops want >=3", npop); end
   endtask

   task automatic test_stream();
      exp_t e;
      int   npop;
      int   last;
      restart();
      fif.pc_in     = 32'h100;
      fif.req_ready = 1'b1;
      fif.if_ready  = 1'b1;
      auto_mem      = 1'b1;
      npop          = 0;
      last          = -1;
      for (int c = 0; c < 14; c++) begin
         cycle();
         if (obs_pop) begin
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_pop: got pc %h want nothing", obs_pc); end
            else begin
               e = exp_q.pop_front();
               if (obs_pc !== e.pc || obs_instr !== e.instr || obs_pc !== 32'h100 + 32'(4 * npop)) begin
                  n_fail++; $display("FAIL stream_pop: got %h/%h want %h/%h", obs_pc, obs_instr, e.pc, e.instr);
               end
            end
            n_tests++;
            if ((npop == 0 && c != 2) || (npop > 0 && c != last + 1)) begin
               n_fail++; $display("FAIL stream_timing: got pop at cycle %0d want cycle %0d", c, (npop == 0) ? 2 : last + 1);
            end
            last = c;
            npop++;
         end
      end
      n_tests++; if (npop != 12) begin n_fail++; $display("FAIL stream_count: got %0d pops want 12", npop); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   nacc;
      int   npop;
      restart();
      fif.pc_in     = 32'h300;
      fif.req_ready = 1'b1;
      auto_mem      = 1'b1;
      nacc          = 0;
      for (int c = 0; c < DEPTH + 3; c++) begin
         cycle();
         if (obs_acc) nacc++;
      end
      #1;
      n_tests++; if (nacc != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", nacc, DEPTH); end
      n_tests++; if (fif.req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b want 0", fif.req_valid); end
      fif.req_ready = 1'b0;
      fif.if_ready  = 1'b1;
      npop          = 0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (obs_pop) begin
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_pop: got pc %h want nothing", obs_pc); end
            else begin
               e = exp_q.pop_front();
               if (obs_pc !== e.pc || obs_instr !== e.instr) begin
                  n_fail++; $display("FAIL bp_pop: got %h/%h want %h/%h", obs_pc, obs_instr, e.pc, e.instr);
               end
            end
            npop++;
         end
      end
      n_tests++; if (npop != DEPTH || exp_q.size() != 0) begin
         n_fail++; $display("FAIL bp_drain: got %0d pops, %0d left want %0d, 0", npop, exp_q.size(), DEPTH);
      end
   endtask

   task automatic test_flush_drop();
      exp_t e;
      int   npop;
      restart();
      fif.pc_in     = 32'h180;
      fif.req_ready = 1'b1;
      fif.if_ready  = 1'b1;
      cycle();
      cycle();
      fif.flush = 1'b1;
      #1;
      n_tests++; if (fif.req_valid !== 1'b0 || fif.pc_advance !== 1'b0) begin
         n_fail++; $display("FAIL fl_no_accept: got req_valid=%b pc_advance=%b want 0/0", fif.req_valid, fif.pc_advance);
      end
      cycle();
      fif.flush      = 1'b0;
      fif.pc_in      = 32'h200;
      auto_mem       = 1'b1;
      fif.resp_valid = 1'b1;
      fif.resp_data  = imem(pend_q.pop_front());
      npop           = 0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (obs_pop) begin
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL fl_pop: got pc %h want nothing", obs_pc); end
            else begin
               e = exp_q.pop_front();
               if (obs_pc !== e.pc || obs_instr !== e.instr || (npop == 0 && obs_pc !== 32'h200)) begin
                  n_fail++; $display("FAIL fl_pop: got %h/%h want %h/%h", obs_pc, obs_instr, e.pc, e.instr);
               end
            end
            npop++;
         end
      end
      n_tests++; if (npop < 2) begin n_fail++; $display("FAIL fl_resume: got %0d pops want >=2", npop); end
   endtask

   task automatic test_flush_resp();
      exp_t e;
      int   npop;
      restart();
      fif.pc_in     = 32'h1c0;
      fif.req_ready = 1'b1;
      cycle();
      cycle();
      fif.req_ready  = 1'b0;
      fif.resp_valid = 1'b1;
      fif.resp_data  = imem(pend_q.pop_front());
      cycle();
      #1;
      n_tests++; if (fif.if_valid !== 1'b1) begin n_fail++; $display("FAIL fr_head_ready: got %b want 1", fif.if_valid); end
      fif.flush      = 1'b1;
      fif.if_ready   = 1'b1;
      fif.resp_valid = 1'b1;
      fif.resp_data  = imem(pend_q.pop_front());
      #1;
      n_tests++; if (fif.if_valid !== 1'b0) begin n_fail++; $display("FAIL fr_if_valid: got %b want 0", fif.if_valid); end
      cycle();
      n_tests++; if (obs_pop !== 1'b0) begin n_fail++; $display("FAIL fr_no_pop: got pop pc %h want none", obs_pc); end
      fif.flush     = 1'b0;
      fif.pc_in     = 32'h240;
      fif.req_ready = 1'b1;
      auto_mem      = 1'b1;
      npop          = 0;
      for (int c = 0; c < 8; c++) begin
         cycle();
         if (obs_pop) begin
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL fr_pop: got pc %h want nothing", obs_pc); end
            else begin
               e = exp_q.pop_front();
               if (obs_pc !== e.pc || obs_instr !== e.instr || (npop == 0 && obs_pc !== 32'h240)) begin
                  n_fail++; $display("FAIL fr_pop: got %h/%h want %h/%h", obs_pc, obs_instr, e.pc, e.instr);
               end
            end
            npop++;
         end
      end
      n_tests++; if (npop < 3) begin n_fail++; $display("FAIL fr_resume: got %0d pops want >=3", npop); end
   endtask

   task automatic test_misalign();
      restart();
      fif.pc_in = 32'hFFFF_FFFC;
      #1;
      n_tests++; if (fif.pc_next !== 32'h0) begin n_fail++; $display("FAIL ma_pc_next_wrap: got %h want 00000000", fif.pc_next); end
      fif.req_ready = 1'b1;
      cycle();
      fif.req_ready = 1'b0;
      auto_mem      = 1'b1;
      cycle();
      cycle();
      #1;
      n_tests++; if (fif.if_valid !== 1'b1 || fif.if_pc !== 32'hFFFF_FFFC || fif.if_pc_plus4 !== 32'h0 || fif.if_instr !== imem(32'hFFFF_FFFC)) begin
         n_fail++; $display("FAIL ma_plus4_wrap: got v=%b pc=%h pc4=%h instr=%h want 1/fffffffc/00000000/%h",
                            fif.if_valid, fif.if_pc, fif.if_pc_plus4, fif.if_instr, imem(32'hFFFF_FFFC));
      end
      fif.pc_in     = 32'h102;
      fif.req_ready = 1'b1;
      #1;
      n_tests++; if (fif.req_valid !== 1'b0 || fif.pc_advance !== 1'b0) begin
         n_fail++; $display("FAIL ma_no_req: got req_valid=%b pc_advance=%b want 0/0", fif.req_valid, fif.pc_advance);
      end
      cycle();
      #1;
      n_tests++; if (fif.fetch_fault !== 1'b1) begin n_fail++; $display("FAIL ma_fault_set: got %b want 1", fif.fetch_fault); end
      fif.pc_in    = 32'h104;
      fif.if_ready = 1'b1;
      cycle();
      n_tests++; if (obs_pop !== 1'b1 || obs_pc !== 32'hFFFF_FFFC) begin
         n_fail++; $display("FAIL ma_drain: got pop=%b pc=%h want 1/fffffffc", obs_pop, obs_pc);
      end
      #1;
      n_tests++; if (fif.fetch_fault !== 1'b1 || fif.req_valid !== 1'b0) begin
         n_fail++; $display("FAIL ma_sticky: got fault=%b req_valid=%b want 1/0", fif.fetch_fault, fif.req_valid);
      end
   endtask

   initial begin
      reset         = 1'b1;
      fif.pc_in     = 32'h40;
      fif.flush     = 1'b0;
      fif.req_ready = 1'b0;
      fif.resp_valid = 1'b0;
      fif.resp_data = '0;
      fif.if_ready  = 1'b0;
      auto_mem      = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_drop();
      test_flush_resp();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
